// File: rtl/gcd_engine.sv
// gcd_engine: subtractive Euclid GCD with operand/result valid-ready handshakes,
// zero-operand shortcut and a saturating CALC-step counter.
module gcd_engine #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_out,
   output logic [CNT_W-1:0] cycles,
   output logic             zero_err
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t           state_q;
   logic [WIDTH-1:0] a_q, b_q, gcd_q;
   logic [CNT_W-1:0] cycles_q;
   logic             zero_err_q;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         a_q        <= '0;
         b_q        <= '0;
         gcd_q      <= '0;
         cycles_q   <= '0;
         zero_err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               a_q        <= a_in;
               b_q        <= b_in;
               cycles_q   <= '0;
               zero_err_q <= 1'b0;
               // a zero operand short-circuits: the other operand (or 0) is the answer
               if (a_in == '0 || b_in == '0) begin
                  gcd_q      <= a_in | b_in;
                  zero_err_q <= a_in == '0 && b_in == '0;
                  state_q    <= DONE;
               end else state_q <= CALC;
            end
            CALC: begin
               cycles_q <= cycles_q + {{(CNT_W-1){1'b0}}, ~&cycles_q};
               if (a_q == b_q) begin
                  gcd_q   <= a_q;
                  state_q <= DONE;
               end else if (a_q > b_q) a_q <= a_q - b_q;
               else b_q <= b_q - a_q;
            end
            DONE: if (out_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   assign in_ready  = state_q == IDLE;
   assign out_valid = state_q == DONE;
   assign gcd_out   = gcd_q;
   assign cycles    = cycles_q;
   assign zero_err  = zero_err_q;
endmodule

// File: tb/tb_gcd_engine.sv
// tb_gcd_engine: directed and randomized checks of gcd_engine against a
// division-based Euclid model (step count = sum of quotients).
module tb_gcd_engine;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] a_in = '0, b_in = '0;
   logic        in_ready, out_valid, zero_err;
   logic [15:0] gcd_out, cycles;
   logic        s_in_valid = 1'b0, s_out_ready = 1'b0;
   logic [15:0] s_a_in = '0, s_b_in = '0;
   logic        s_in_ready, s_out_valid, s_zero_err;
   logic [15:0] s_gcd_out;
   logic [7:0]  s_cycles;
   int          n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   gcd_engine #(.WIDTH(16), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a_in(a_in), .b_in(b_in), .out_valid(out_valid), .out_ready(out_ready),
      .gcd_out(gcd_out), .cycles(cycles), .zero_err(zero_err));

   gcd_engine #(.WIDTH(16), .CNT_W(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .a_in(s_a_in), .b_in(s_b_in), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .gcd_out(s_gcd_out), .cycles(s_cycles), .zero_err(s_zero_err));

   // Euclid by division; each quotient equals that many subtractive steps
   // (the last one ending in the A==B step), saturated to the counter range.
   function automatic void ref_gcd(input int unsigned a, input int unsigned b,
                                   input int unsigned cmax, output int unsigned g,
                                   output int unsigned c, output bit z);
      int unsigned x = a, y = b, t;
      c = 0;
      z = (a == 0 && b == 0);
      if (a == 0 || b == 0) begin
         g = a | b;
         return;
      end
      while (y != 0) begin
         c += x / y;
         t = x % y;
         x = y;
         y = t;
      end
      g = x;
      if (c > cmax) c = cmax;
   endfunction

   task automatic run(input logic [15:0] a, input logic [15:0] b, output logic [15:0] g,
                      output logic [15:0] c, output logic z, output int lat);
      @(negedge clk);
      in_valid = 1'b1; a_in = a; b_in = b;
      @(negedge clk);
      in_valid = 1'b0; lat = 0;
      while (!out_valid && lat < 70000) begin
         @(negedge clk);
         lat++;
      end
      g = gcd_out; c = cycles; z = zero_err;
      if (!out_valid) lat = -1;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic check_problem(input string name, input logic [15:0] a, input logic [15:0] b);
      logic [15:0] g, c;
      logic        z;
      int          lat;
      int unsigned eg, ec;
      bit          ez;
      ref_gcd(a, b, 65535, eg, ec, ez);
      run(a, b, g, c, z, lat);
      n_cmp += 4;
      if (g !== 16'(eg)) begin n_err++; $display("FAIL %s gcd a=%0d b=%0d got %0d want %0d", name, a, b, g, eg); end
      if (c !== 16'(ec)) begin n_err++; $display("FAIL %s cycles a=%0d b=%0d got %0d want %0d", name, a, b, c, ec); end
      if (z !== ez) begin n_err++; $display("FAIL %s zero_err a=%0d b=%0d got %0b want %0b", name, a, b, z, ez); end
      if (lat != int'(ec)) begin n_err++; $display("FAIL %s latency a=%0d b=%0d got %0d want %0d", name, a, b, lat, ec); end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      n_cmp += 6;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset in_ready got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset out_valid got %b want 0", out_valid); end
      if (gcd_out !== 16'd0) begin n_err++; $display("FAIL reset gcd_out got %0d want 0", gcd_out); end
      if (cycles !== 16'd0) begin n_err++; $display("FAIL reset cycles got %0d want 0", cycles); end
      if (zero_err !== 1'b0) begin n_err++; $display("FAIL reset zero_err got %b want 0", zero_err); end
      if (s_in_ready !== 1'b1) begin n_err++; $display("FAIL reset s_in_ready got %b want 1", s_in_ready); end
      rst_n = 1'b1;
   endtask

   task automatic test_basic;
      check_problem("basic", 16'd12, 16'd18);
      check_problem("basic", 16'd48, 16'd36);
   endtask

   task automatic test_zero;
      check_problem("zero", 16'd7, 16'd0);
      check_problem("zero", 16'd0, 16'd0);
      check_problem("zero", 16'd0, 16'd5);
   endtask

   task automatic test_boundary;
      check_problem("bound", 16'hFFFF, 16'hFFFF);
      check_problem("bound", 16'hFFFF, 16'd1);
   endtask

   task automatic test_saturation;
      int lat = 0;
      @(negedge clk);
      s_in_valid = 1'b1; s_a_in = 16'd1000; s_b_in = 16'd1;
      @(negedge clk);
      s_in_valid = 1'b0;
      while (!s_out_valid && lat < 5000) begin
         @(negedge clk);
         lat++;
      end
      n_cmp += 3;
      if (!s_out_valid) begin n_err++; $display("FAIL sat timeout got no out_valid want out_valid"); end
      if (s_gcd_out !== 16'd1) begin n_err++; $display("FAIL sat gcd got %0d want 1", s_gcd_out); end
      if (s_cycles !== 8'd255) begin n_err++; $display("FAIL sat cycles got %0d want 255", s_cycles); end
      s_out_ready = 1'b1;
      @(negedge clk);
      s_out_ready = 1'b0;
   endtask

   task automatic test_backpressure;
      int lat = 0;
      logic [15:0] g, c;
      logic        z;
      @(negedge clk);
      in_valid = 1'b1; a_in = 16'd48; b_in = 16'd36;
      @(negedge clk);
      in_valid = 1'b0;
      while (!out_valid && lat < 1000) begin
         @(negedge clk);
         lat++;
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0]; a_in = 16'd9; b_in = 16'd3;
         @(negedge clk);
         n_cmp += 4;
         if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp out_valid got %b want 1", out_valid); end
         if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp in_ready got %b want 0", in_ready); end
         if (gcd_out !== 16'd12) begin n_err++; $display("FAIL bp gcd got %0d want 12", gcd_out); end
         if (cycles !== 16'd4) begin n_err++; $display("FAIL bp cycles got %0d want 4", cycles); end
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      n_cmp += 3;
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp release in_ready got %b want 1", in_ready); end
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp release out_valid got %b want 0", out_valid); end
      if (gcd_out !== 16'd12) begin n_err++; $display("FAIL bp idle hold gcd got %0d want 12", gcd_out); end
      run(16'd9, 16'd3, g, c, z, lat);
      n_cmp++;
      if (g !== 16'd3) begin n_err++; $display("FAIL bp next gcd got %0d want 3", g); end
   endtask

   task automatic test_reset_mid;
      @(negedge clk);
      in_valid = 1'b1; a_in = 16'd1000; b_in = 16'd1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      n_cmp += 4;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid out_valid got %b want 0", out_valid); end
      if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid in_ready got %b want 1", in_ready); end
      if (cycles !== 16'd0) begin n_err++; $display("FAIL rstmid cycles got %0d want 0", cycles); end
      if (gcd_out !== 16'd0) begin n_err++; $display("FAIL rstmid gcd got %0d want 0", gcd_out); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_cmp++;
      if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid after out_valid got %b want 0", out_valid); end
      check_problem("rstmid", 16'd14, 16'd21);
   endtask

   task automatic test_random;
      logic [15:0] a, b;
      for (int i = 0; i < 30; i++) begin
         a = 16'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 400));
         b = 16'($urandom_range(0, 9) == 0 ? 0 : $urandom_range(1, 400));
         check_problem("random", a, b);
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_zero;
      test_boundary;
      test_saturation;
      test_backpressure;
      test_reset_mid;
      test_random;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
